// File: rtl/microwave_timer_pkg.sv
// Shared types and constants for the microwave countdown timer.
// Holds the FSM state enum, BCD digit limits, the 4-bit BCD digit type
// (shared with the 7-segment decoder) and the M:ST:SO decrement helper.
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_ONES = 4'd9;
    localparam bcd_t BCD_MAX_TENS = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    typedef struct packed {
        bcd_t mins;
        bcd_t tens;
        bcd_t ones;
    } bcd_time_t;

    // One-second decrement. Only the ones digit wraps to 9; a tens borrow
    // wraps to 5, so an entered tens digit above 5 counts down linearly.
    function automatic bcd_time_t bcd_decrement(bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.ones != 4'd0) begin
            r.ones = t.ones - 4'd1;
        end else begin
            r.ones = BCD_MAX_ONES;
            if (t.tens != 4'd0) begin
                r.tens = t.tens - 4'd1;
            end else begin
                r.tens = BCD_MAX_TENS;
                r.mins = t.mins - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Keypad/control strobes in, BCD time and status out.
// master: drives digit_valid/digit/start/stop/clear, reads the outputs.
// slave : the timer itself.
interface microwave_timer_if;
    import microwave_pkg::*;

    logic       digit_valid;
    logic [3:0] digit;
    logic       start;
    logic       stop;
    logic       clear;
    bcd_t       mins;
    bcd_t       sec_tens;
    bcd_t       sec_ones;
    logic       running;
    logic       done;

    modport master (
        output digit_valid, digit, start, stop, clear,
        input  mins, sec_tens, sec_ones, running, done
    );

    modport slave (
        input  digit_valid, digit, start, stop, clear,
        output mins, sec_tens, sec_ones, running, done
    );

endinterface

// File: rtl/microwave_timer_tick_prescaler.sv
// One-cycle tick generator: counts 0..TICK_DIV-1 while enabled and pulses
// tick on the cycle it wraps. When disabled the count is held.
// Ports: clk, rst_n (async active-low), enable, sync_clear (forces 0,
// overrides enable), tick (combinational decode of the count register).
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic sync_clear,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        tick    = enable && (count_q == LastCnt);
        count_d = count_q;
        if (sync_clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LastCnt) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad entry into M:ST:SO BCD, 1 Hz countdown
// with pause/resume/clear, done indication at 0:00.
// Ports: clk, rst_n (async active-low), bus (microwave_timer_if.slave).
// Input priority per cycle: clear > stop > start > digit_valid > tick.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    microwave_timer_if.slave        bus
);

    state_e    state_q, state_d;
    bcd_time_t time_q, time_d;
    bcd_time_t time_dec;
    logic      tick;
    logic      pre_enable;
    logic      pre_clear;

    // Prescaler only advances in RUN and freezes on the cycle stop/clear
    // arrive, so a stop on the tick cycle suppresses the decrement and the
    // held count is resumed later. IDLE/DONE keep it parked at 0.
    assign pre_enable = (state_q == StRun) && !bus.clear && !bus.stop;
    assign pre_clear  = bus.clear || (state_q == StIdle) || (state_q == StDone);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (pre_enable),
        .sync_clear (pre_clear),
        .tick       (tick)
    );

    assign time_dec = bcd_decrement(time_q);

    // State and time registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            time_q  <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear || bus.stop) begin
                    time_d = '0;
                end else if (bus.start) begin
                    if (time_q != '0) state_d = StRun;
                end else if (bus.digit_valid && (bus.digit <= BCD_MAX_ONES)) begin
                    time_d = '{mins: time_q.tens, tens: time_q.ones, ones: bus.digit};
                end
            end
            StRun: begin
                if (bus.clear) begin
                    state_d = StIdle;
                    time_d  = '0;
                end else if (bus.stop) begin
                    state_d = StPause;
                end else if (tick) begin
                    time_d = time_dec;
                    if (time_dec == '0) state_d = StDone;
                end
            end
            StPause: begin
                if (bus.clear || bus.stop) begin
                    state_d = StIdle;
                    time_d  = '0;
                end else if (bus.start) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                time_d = '0;
                if (bus.clear || bus.stop || bus.start) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                time_d  = '0;
            end
        endcase
    end

    // Outputs decode registers only.
    always_comb begin
        bus.running  = (state_q == StRun);
        bus.done     = (state_q == StDone);
        bus.mins     = time_q.mins;
        bus.sec_tens = time_q.tens;
        bus.sec_ones = time_q.ones;
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_microwave_timer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    microwave_timer_if bus();

    microwave_timer #(
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [11:0] t_obs;
    assign t_obs = {bus.mins, bus.sec_tens, bus.sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [11:0] t_exp, input logic run_exp,
                          input logic done_exp);
        chk({tag, ".time"}, t_obs, t_exp);
        chk({tag, ".running"}, {11'd0, bus.running}, {11'd0, run_exp});
        chk({tag, ".done"}, {11'd0, bus.done}, {11'd0, done_exp});
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        cyc(1);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        n_cmp           = 0;
        n_bad           = 0;
        rst_n           = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear       = 1'b0;

        // 1. Reset defaults and digit entry.
        cyc(3);
        chk_st("reset", 12'h000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1);
        press(4'd5);
        chk("entry1", t_obs, 12'h005);
        press(4'd4);
        press(4'd2);
        chk_st("entry542", 12'h542, 1'b0, 1'b0);

        // 2. Borrow chain from 1:00.
        do_clear();
        press(4'd1);
        press(4'd0);
        press(4'd0);
        chk("load100", t_obs, 12'h100);
        do_start();
        chk_st("start100", 12'h100, 1'b1, 1'b0);
        cyc(3);
        chk("pre_tick", t_obs, 12'h100);
        cyc(1);
        chk("borrow059", t_obs, 12'h059);
        cyc(40);
        chk("tick049", t_obs, 12'h049);

        // 3. Full countdown into DONE, start returns to IDLE.
        do_clear();
        chk_st("clear_run", 12'h000, 1'b0, 1'b0);
        press(4'd0);
        press(4'd2);
        do_start();
        cyc(4);
        chk("cd001", t_obs, 12'h001);
        cyc(3);
        chk_st("cd_before0", 12'h001, 1'b1, 1'b0);
        cyc(1);
        chk_st("cd_done", 12'h000, 1'b0, 1'b1);
        cyc(3);
        chk_st("done_hold", 12'h000, 1'b0, 1'b1);
        do_start();
        chk_st("done_to_idle", 12'h000, 1'b0, 1'b0);
        press(4'd6);
        chk("idle_after_done", t_obs, 12'h006);

        // 4. Pause, resume from held prescaler, cancel.
        do_clear();
        press(4'd1);
        press(4'd0);
        do_start();
        cyc(4);
        chk("p009", t_obs, 12'h009);
        cyc(2);
        do_stop();
        chk_st("pause", 12'h009, 1'b0, 1'b0);
        press(4'd7);
        cyc(10);
        chk("pause_hold", t_obs, 12'h009);
        do_start();
        chk("resume", {11'd0, bus.running}, 12'h001);
        cyc(1);
        chk("resume1", t_obs, 12'h009);
        cyc(1);
        chk("resume008", t_obs, 12'h008);
        do_stop();
        chk_st("pause2", 12'h008, 1'b0, 1'b0);
        do_stop();
        chk_st("cancel", 12'h000, 1'b0, 1'b0);
        press(4'd3);
        chk("idle_after_cancel", t_obs, 12'h003);

        // 5. Priority cases.
        do_clear();
        press(4'd2);
        press(4'd0);
        do_start();
        cyc(2);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk_st("clear_start", 12'h000, 1'b0, 1'b0);
        press(4'd3);
        press(4'd0);
        do_start();
        cyc(3);
        do_stop();
        chk_st("stop_on_tick", 12'h030, 1'b0, 1'b0);
        do_start();
        cyc(1);
        chk("resume_at_wrap", t_obs, 12'h029);
        do_clear();
        press(4'd7);
        press(4'd12);
        chk("digit12", t_obs, 12'h007);

        // 6. Edge entries and async reset.
        do_clear();
        do_start();
        chk_st("start_zero", 12'h000, 1'b0, 1'b0);
        press(4'd9);
        press(4'd9);
        chk("load099", t_obs, 12'h099);
        do_start();
        cyc(4);
        chk("lin098", t_obs, 12'h098);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 12'h000, 1'b0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(8);
        chk_st("post_rst", 12'h000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
